// File: rtl/instr_encoder.sv
// Instruction encoder: turns ADDI/BNE/END field tuples into RV32 words and writes them to instruction memory.
// Latency: a word accepted on edge N is strobed on mem_we during the cycle after edge N; one word per 2 cycles.
// Backpressure: in_ready is high only in LOAD with room left; it drops for the write cycle and once done/error/full.
module instr_encoder #(
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [1:0]            in_op,
    input  logic [4:0]            in_rd,
    input  logic [4:0]            in_rs1,
    input  logic [4:0]            in_rs2,
    input  logic [12:0]           in_imm,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]           mem_wdata,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  done,
    output logic                  full,
    output logic                  err
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LOAD  = 3'd1;
    localparam logic [2:0] S_WRITE = 3'd2;
    localparam logic [2:0] S_DONE  = 3'd3;
    localparam logic [2:0] S_ERROR = 3'd4;

    // Word count that means "memory full": a one followed by ADDR_WIDTH zeros.
    localparam logic [ADDR_WIDTH:0] DEPTH_CNT = {1'b1, {ADDR_WIDTH{1'b0}}};

    logic [2:0]            state;
    logic [ADDR_WIDTH:0]   count_q;
    logic [ADDR_WIDTH:0]   count_inc;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [31:0]           wdata_q;
    logic                  end_q;

    logic [31:0]           enc_word;
    logic                  enc_illegal;
    logic                  enc_is_end;
    logic                  take;

    // Decode the incoming fields into an RV32 word and flag illegal requests.
    always_comb begin
        enc_word    = 32'h0000_0000;
        enc_illegal = 1'b0;
        enc_is_end  = 1'b0;
        case (in_op)
            2'b00: begin
                enc_word = {in_imm[11:0], in_rs1, 3'b000, in_rd, 7'b0010011};
            end
            2'b01: begin
                enc_word    = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, 3'b001,
                               in_imm[4:1], in_imm[11], 7'b1100011};
                // Branch offsets must be even; an odd offset cannot be encoded.
                enc_illegal = in_imm[0];
            end
            2'b11: begin
                enc_word   = 32'h0000_0063;
                enc_is_end = 1'b1;
            end
            default: begin
                enc_illegal = 1'b1;
            end
        endcase
    end

    assign count_inc = count_q + 1'b1;
    assign full      = (count_q == DEPTH_CNT);
    assign in_ready  = (state == S_LOAD) && !full;
    assign take      = in_valid && in_ready;

    assign mem_we    = (state == S_WRITE);
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign count     = count_q;
    assign done      = (state == S_DONE);
    assign err       = (state == S_ERROR);

    // Session state machine plus the registered write address/data and word count.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            count_q <= '0;
            addr_q  <= '0;
            wdata_q <= 32'h0000_0000;
            end_q   <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_DONE, S_ERROR: begin
                    if (start) begin
                        state   <= S_LOAD;
                        count_q <= '0;
                    end
                end
                S_LOAD: begin
                    if (take) begin
                        if (enc_illegal) begin
                            state <= S_ERROR;
                        end else begin
                            addr_q  <= count_q[ADDR_WIDTH-1:0];
                            wdata_q <= enc_word;
                            end_q   <= enc_is_end;
                            state   <= S_WRITE;
                        end
                    end
                end
                S_WRITE: begin
                    count_q <= count_inc;
                    if (end_q || (count_inc == DEPTH_CNT)) begin
                        state <= S_DONE;
                    end else begin
                        state <= S_LOAD;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_encoder.sv
// Testbench for instr_encoder (ADDR_WIDTH = 2): directed vectors, fill-to-full, random sessions, reset mid-transfer.
// Expected writes go into a scoreboard queue; a negedge monitor pops and compares on every mem_we.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_instr_encoder;

    localparam int AW    = 2;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [1:0]    in_op = 2'b00;
    logic [4:0]    in_rd = '0;
    logic [4:0]    in_rs1 = '0;
    logic [4:0]    in_rs2 = '0;
    logic [12:0]   in_imm = '0;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic [AW:0]   count;
    logic          done;
    logic          full;
    logic          err;

    instr_encoder #(.ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .count(count), .done(done), .full(full), .err(err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int model_cnt = 0;
    bit session_over = 0;
    logic [33:0] sb[$];
    int wr_cyc[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: every write strobe must match the oldest expected write.
    always @(negedge clk) begin
        cyc++;
        if (mem_we === 1'b1) begin
            wr_cyc.push_back(cyc);
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write: addr %0d data 0x%08h with nothing expected", mem_addr, mem_wdata);
            end else begin
                logic [33:0] e;
                e = sb.pop_front();
                if ({mem_addr, mem_wdata} !== e) begin
                    errors++;
                    $display("FAIL write: got addr %0d data 0x%08h expected addr %0d data 0x%08h",
                             mem_addr, mem_wdata, e[33:32], e[31:0]);
                end
            end
        end
    end

    // Reference encoding, built from the instruction-format rules with plain arithmetic.
    function automatic logic [31:0] ref_word(input int unsigned op, input int unsigned rd,
                                             input int unsigned rs1, input int unsigned rs2,
                                             input int unsigned imm);
        int unsigned w;
        case (op)
            0: w = ((imm % 4096) << 20) + (rs1 << 15) + (rd << 7) + 32'h13;
            1: w = (((imm / 4096) % 2) << 31) + (((imm / 32) % 64) << 25) + (rs2 << 20)
                 + (rs1 << 15) + (1 << 12) + (((imm / 2) % 16) << 8)
                 + (((imm / 2048) % 2) << 7) + 32'h63;
            default: w = 32'h63;
        endcase
        return w;
    endfunction

    task automatic start_session();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        model_cnt = 0;
        session_over = 0;
        chk("start_ready", {31'b0, in_ready}, 32'd1);
        chk("start_count", {29'b0, count}, 32'd0);
        chk("start_flags", {29'b0, done, err, full}, 32'd0);
    endtask

    // Offer one instruction, wait for acceptance, then check the session-level outcome.
    task automatic send(input logic [1:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                        input logic [4:0] rs2, input logic [12:0] imm,
                        input bit legal, input logic [31:0] exp_word, input bit is_end);
        int waited;
        logic [1:0] a;
        waited = 0;
        in_op = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2; in_imm = imm;
        in_valid = 1'b1;
        while (in_ready !== 1'b1 && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        if (in_ready !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL handshake_timeout: in_ready stayed %b for %0d cycles", in_ready, waited);
            in_valid = 1'b0;
            session_over = 1;
            return;
        end
        a = model_cnt[1:0];
        if (legal) sb.push_back({a, exp_word});
        @(negedge clk);
        in_valid = 1'b0;
        chk("ready_low_after_xfer", {31'b0, in_ready}, 32'd0);
        if (legal) begin
            @(negedge clk);
            model_cnt++;
            chk("count_after_write", {29'b0, count}, model_cnt);
            chk("wdata_hold", mem_wdata, exp_word);
            chk("addr_hold", {30'b0, mem_addr}, {30'b0, a});
            if (is_end || model_cnt == DEPTH) begin
                chk("done_set", {31'b0, done}, 32'd1);
                chk("ready_in_done", {31'b0, in_ready}, 32'd0);
                chk("full_flag", {31'b0, full}, (model_cnt == DEPTH) ? 32'd1 : 32'd0);
                session_over = 1;
            end else begin
                chk("ready_back", {31'b0, in_ready}, 32'd1);
            end
        end else begin
            chk("err_set", {31'b0, err}, 32'd1);
            chk("count_on_err", {29'b0, count}, model_cnt);
            chk("done_on_err", {31'b0, done}, 32'd0);
            session_over = 1;
        end
    endtask

    initial begin
        // Reset
        repeat (3) @(negedge clk);
        chk("reset_outputs", {mem_wdata[31:8], in_ready, mem_we, mem_addr, done, full, err, 1'b0},
            32'd0);
        chk("reset_wdata_lo", {24'b0, mem_wdata[7:0]}, 32'd0);
        chk("reset_count", {29'b0, count}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_ready", {31'b0, in_ready}, 32'd0);

        // Directed vectors
        start_session();
        send(2'b00, 5'd1, 5'd0, 5'd0, 13'h00FF, 1, 32'h0FF00093, 0);
        send(2'b01, 5'd0, 5'd1, 5'd0, 13'h1FFC, 1, 32'hFE009EE3, 0);
        send(2'b11, 5'd7, 5'd3, 5'd9, 13'h1234, 1, 32'h00000063, 1);
        chk("end_count", {29'b0, count}, 32'd3);
        start_session();

        // Illegal op
        send(2'b10, 5'd1, 5'd2, 5'd3, 13'h0004, 0, 32'h0, 0);
        start_session();
        chk("err_cleared", {31'b0, err}, 32'd0);
        // Odd branch offset after one good word
        send(2'b00, 5'd5, 5'd6, 5'd0, 13'h0ABC, 1, ref_word(0, 5, 6, 0, 'hABC), 0);
        send(2'b01, 5'd0, 5'd1, 5'd2, 13'h0003, 0, 32'h0, 0);
        chk("err_count_kept", {29'b0, count}, 32'd1);
        start_session();
        chk("err_cleared2", {31'b0, err}, 32'd0);

        // Fill memory with back-to-back ADDIs
        wr_cyc.delete();
        for (int k = 0; k < DEPTH; k++) begin
            send(2'b00, 5'(k + 1), 5'(k), 5'd0, 13'(k * 17),
                 1, ref_word(0, k + 1, k, 0, k * 17), 0);
        end
        chk("fill_writes", wr_cyc.size(), DEPTH);
        for (int k = 1; k < wr_cyc.size(); k++) chk("fill_spacing", wr_cyc[k] - wr_cyc[k-1], 32'd2);
        in_valid = 1'b1;
        repeat (5) @(negedge clk);
        in_valid = 1'b0;
        chk("fill_full", {31'b0, full}, 32'd1);
        chk("fill_done", {31'b0, done}, 32'd1);

        // Random sessions
        for (int s = 0; s < 40; s++) begin
            start_session();
            while (!session_over) begin
                int unsigned r, op, rd, rs1, rs2, imm;
                bit legal;
                r   = $urandom_range(0, 9);
                op  = (r < 5) ? 0 : (r < 8) ? 1 : (r == 8) ? 3 : 2;
                rd  = $urandom_range(0, 31);
                rs1 = $urandom_range(0, 31);
                rs2 = $urandom_range(0, 31);
                imm = $urandom_range(0, 8191);
                if (op == 1 && $urandom_range(0, 3) != 0) imm = imm & 32'h1FFE;
                legal = !(op == 2 || (op == 1 && (imm % 2) == 1));
                send(2'(op), 5'(rd), 5'(rs1), 5'(rs2), 13'(imm), legal,
                     ref_word(op, rd, rs1, rs2, imm), op == 3);
            end
        end

        // Reset on the edge that would have accepted a transfer
        start_session();
        in_op = 2'b00; in_rd = 5'd3; in_rs1 = 5'd4; in_imm = 13'h0055;
        in_valid = 1'b1;
        rst_n = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        chk("rst_xfer_ctl", {26'b0, in_ready, mem_we, done, full, err, 1'b0}, 32'd0);
        chk("rst_xfer_addr", {30'b0, mem_addr}, 32'd0);
        chk("rst_xfer_wdata", mem_wdata, 32'd0);
        chk("rst_xfer_count", {29'b0, count}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_idle_ready", {31'b0, in_ready}, 32'd0);
        chk("rst_no_we", {31'b0, mem_we}, 32'd0);

        repeat (2) @(negedge clk);
        chk("scoreboard_empty", sb.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
